mux4_rr_arbiter: RTL and testbench

//   Round-robin arbiter that shares the 4:1 gate-level mux (fourOneMux) between four requesters.

---
 rtl/mux4_arb_pkg.sv | 28 ++
 rtl/mux4_rr_arbiter_rr_pick.sv | 42 ++++
 rtl/mux4_rr_arbiter.sv | 150 +++++++++++++++
 tb/tb_mux4_rr_arbiter.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/mux4_arb_pkg.sv
// ---------------------------------------------------------------------------
// mux4_arb_pkg
// Shared definitions for the round-robin arbiter that sits in front of the
// fourOneMux gate-level mux.
//   N_REQ        number of requesters (one per mux input)
//   SEL_W        width of the mux select / requester index
//   arb_state_t  arbiter FSM state (IDLE, GRANT)
//   idx2onehot   converts a requester index to a one-hot request-sized vector
// ---------------------------------------------------------------------------
package mux4_arb_pkg;

    localparam int N_REQ = 4;
    localparam int SEL_W = 2;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

    // Turns a requester index into the matching one-hot grant/mask pattern.
    function automatic logic [N_REQ-1:0] idx2onehot(input logic [SEL_W-1:0] idx);
        logic [N_REQ-1:0] oh;
        oh      = '0;
        oh[idx] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/mux4_rr_arbiter_rr_pick.sv
// ---------------------------------------------------------------------------
// rr_pick
// Combinational rotating-priority encoder. Searches the eligible requests
// (req & mask) starting at index ptr and moving upward modulo N_REQ; the
// first set bit wins.
//   req_i    in   N_REQ  raw request vector
//   ptr_i    in   SEL_W  index where the search starts
//   mask_i   in   N_REQ  1 = requester may be picked, 0 = excluded
//   found_o  out  1      at least one eligible request exists
//   idx_o    out  SEL_W  index of the winning requester (ptr_i when none)
// ---------------------------------------------------------------------------
module rr_pick
    import mux4_arb_pkg::*;
(
    input  logic [N_REQ-1:0] req_i,
    input  logic [SEL_W-1:0] ptr_i,
    input  logic [N_REQ-1:0] mask_i,
    output logic             found_o,
    output logic [SEL_W-1:0] idx_o
);

    logic [N_REQ-1:0] eligible;
    logic [SEL_W-1:0] cand;

    assign eligible = req_i & mask_i;

    // Walk the N_REQ positions starting at ptr_i; the index arithmetic wraps
    // naturally because cand is exactly SEL_W bits wide.
    always_comb begin
        found_o = 1'b0;
        idx_o   = ptr_i;
        cand    = ptr_i;
        for (int i = 0; i < N_REQ; i++) begin
            cand = ptr_i + SEL_W'(i);
            if (!found_o && eligible[cand]) begin
                found_o = 1'b1;
                idx_o   = cand;
            end
        end
    end

endmodule

// File: rtl/mux4_rr_arbiter.sv
// ---------------------------------------------------------------------------
// mux4_rr_arbiter
// Round-robin arbiter sharing the fourOneMux between four requesters. One
// requester is granted at a time; the select lines drive the mux directly
// (sel_o[1] -> s1_i, sel_o[0] -> s0_i). A hold limit bounds each burst while
// somebody else is waiting, so nobody starves. All outputs are registered;
// there is no combinational path from req_i to any output.
//   clk_i     in   1      clock, rising edge
//   rst_n_i   in   1      asynchronous active-low reset
//   req_i     in   4      level requests, bit k = requester k
//   grant_o   out  4      one-hot grant, zero when idle
//   sel_o     out  2      index of granted requester, holds value when idle
//   busy_o    out  1      high while any grant is active
// Parameters:
//   MAX_HOLD  consecutive cycles a contested grant may be held (>= 1)
//   CNT_W     hold counter width, 2**CNT_W must exceed MAX_HOLD
// ---------------------------------------------------------------------------
module mux4_rr_arbiter
    import mux4_arb_pkg::*;
#(
    parameter int unsigned MAX_HOLD = 4,
    parameter int unsigned CNT_W    = 3
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic [N_REQ-1:0] req_i,
    output logic [N_REQ-1:0] grant_o,
    output logic [SEL_W-1:0] sel_o,
    output logic             busy_o
);

    arb_state_t       state_q, state_d;
    logic [N_REQ-1:0] grant_q, grant_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic             busy_q, busy_d;
    logic [SEL_W-1:0] rrPtr_q, rrPtr_d;
    logic [CNT_W-1:0] holdCnt_q, holdCnt_d;

    logic             ownerReq;
    logic             otherReq;
    logic             holdExpired;
    logic [N_REQ-1:0] pickMask;
    logic             pickFound;
    logic [SEL_W-1:0] pickIdx;
    logic             doGrant;
    logic             doHold;

    // The current owner is always the requester named by sel_q while in GRANT.
    assign ownerReq    = req_i[sel_q];
    assign otherReq    = |(req_i & ~idx2onehot(sel_q));
    assign holdExpired = (holdCnt_q == CNT_W'(MAX_HOLD - 1));

    // On hold expiry the owner is still requesting but must step aside, so it
    // is masked out of the search. On release its request bit is already 0.
    always_comb begin
        pickMask = '1;
        if (state_q == GRANT && ownerReq && holdExpired) begin
            pickMask = ~idx2onehot(sel_q);
        end
    end

    rr_pick u_rr_pick (
        .req_i   (req_i),
        .ptr_i   (rrPtr_q),
        .mask_i  (pickMask),
        .found_o (pickFound),
        .idx_o   (pickIdx)
    );

    // State register together with the registered outputs, pointer and
    // hold counter; everything clears asynchronously.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q   <= IDLE;
            grant_q   <= '0;
            sel_q     <= '0;
            busy_q    <= 1'b0;
            rrPtr_q   <= '0;
            holdCnt_q <= '0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            sel_q     <= sel_d;
            busy_q    <= busy_d;
            rrPtr_q   <= rrPtr_d;
            holdCnt_q <= holdCnt_d;
        end
    end

    // Next-state decision. A release always wins over expiry because the
    // owner-request test comes first; new arrivals only matter at release
    // or once the hold counter has reached its limit.
    always_comb begin
        state_d = state_q;
        doGrant = 1'b0;
        doHold  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (pickFound) begin
                    state_d = GRANT;
                    doGrant = 1'b1;
                end
            end
            GRANT: begin
                if (!ownerReq) begin
                    if (pickFound) begin
                        doGrant = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (holdExpired && otherReq) begin
                    doGrant = 1'b1;
                end else begin
                    doHold = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output/datapath next values. A new grant restarts the hold counter and
    // moves the round-robin pointer just past the new owner. The counter
    // saturates so a sole requester keeps the grant indefinitely.
    always_comb begin
        grant_d   = grant_q;
        sel_d     = sel_q;
        busy_d    = busy_q;
        rrPtr_d   = rrPtr_q;
        holdCnt_d = holdCnt_q;
        if (doGrant) begin
            grant_d   = idx2onehot(pickIdx);
            sel_d     = pickIdx;
            busy_d    = 1'b1;
            rrPtr_d   = pickIdx + SEL_W'(1);
            holdCnt_d = '0;
        end else if (state_d == IDLE) begin
            grant_d = '0;
            busy_d  = 1'b0;
        end else if (doHold && !holdExpired) begin
            holdCnt_d = holdCnt_q + CNT_W'(1);
        end
    end

    assign grant_o = grant_q;
    assign sel_o   = sel_q;
    assign busy_o  = busy_q;

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mux4_rr_arbiter
// Self-checking bench for mux4_rr_arbiter with MAX_HOLD=4. A table of
// {request, expected grant/sel/busy} records is applied one per clock after
// reset, followed by hand-written sequences for the sole-requester, expiry
// after saturation and asynchronous mid-cycle reset cases. Invariants are
// checked on every falling edge.
// ---------------------------------------------------------------------------
module tb_mux4_rr_arbiter;

    logic       clk_i;
    logic       rst_n_i;
    logic [3:0] req_i;
    logic [3:0] grant_o;
    logic [1:0] sel_o;
    logic       busy_o;

    int testsRun;
    int testsFailed;

    typedef struct {
        logic [3:0] req;
        logic [3:0] grant;
        logic [1:0] sel;
        logic       busy;
    } vec_t;

    vec_t       vecs[$];
    logic [3:0] reqAtEdge;

    mux4_rr_arbiter #(
        .MAX_HOLD (4),
        .CNT_W    (3)
    ) dut (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .req_i   (req_i),
        .grant_o (grant_o),
        .sel_o   (sel_o),
        .busy_o  (busy_o)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // Remember what the DUT saw at each rising edge for the grant-legality check.
    always @(posedge clk_i) reqAtEdge <= req_i;

    // Drive a request on the falling edge, then settle just after the next rising edge.
    task automatic applyStimulus(input logic [3:0] req);
        @(negedge clk_i);
        req_i = req;
        @(posedge clk_i);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [3:0] expGrant,
                               input logic [1:0] expSel, input logic expBusy);
        testsRun++;
        if (grant_o !== expGrant || sel_o !== expSel || busy_o !== expBusy) begin
            testsFailed++;
            $display("[TB] FAIL %s: got grant=%b sel=%0d busy=%b, expected grant=%b sel=%0d busy=%b",
                     name, grant_o, sel_o, busy_o, expGrant, expSel, expBusy);
        end
    endtask

    // Structural invariants, evaluated mid-cycle while out of reset.
    always @(negedge clk_i) begin
        if (rst_n_i) begin
            testsRun++;
            if (!$onehot0(grant_o) || (busy_o !== (|grant_o)) ||
                (busy_o && grant_o[sel_o] !== 1'b1) || ((grant_o & ~reqAtEdge) != 4'b0000)) begin
                testsFailed++;
                $display("[TB] FAIL invariant: grant=%b sel=%0d busy=%b reqAtEdge=%b",
                         grant_o, sel_o, busy_o, reqAtEdge);
            end
        end
    end

    initial begin
        testsRun    = 0;
        testsFailed = 0;
        rst_n_i     = 1'b0;
        req_i       = 4'b0000;

        // All requesting from reset: owners 0,1,2,3,0 each for exactly four cycles.
        for (int k = 0; k < 4; k++) vecs.push_back('{4'b1111, 4'b0001, 2'd0, 1'b1});
        for (int k = 0; k < 4; k++) vecs.push_back('{4'b1111, 4'b0010, 2'd1, 1'b1});
        for (int k = 0; k < 4; k++) vecs.push_back('{4'b1111, 4'b0100, 2'd2, 1'b1});
        for (int k = 0; k < 4; k++) vecs.push_back('{4'b1111, 4'b1000, 2'd3, 1'b1});
        vecs.push_back('{4'b1111, 4'b0001, 2'd0, 1'b1});
        vecs.push_back('{4'b0000, 4'b0000, 2'd0, 1'b0});
        // Single request to requester 2 (pointer is 1), then back to idle.
        vecs.push_back('{4'b0100, 4'b0100, 2'd2, 1'b1});
        vecs.push_back('{4'b0000, 4'b0000, 2'd2, 1'b0});
        // Owner 1, requester 3 arrives, owner 1 releases: handoff to 3 with no bubble.
        vecs.push_back('{4'b0010, 4'b0010, 2'd1, 1'b1});
        vecs.push_back('{4'b1010, 4'b0010, 2'd1, 1'b1});
        vecs.push_back('{4'b1000, 4'b1000, 2'd3, 1'b1});
        // Owner 3 releases to idle, sel holds; pointer wrapped to 0 so 0 wins over 3.
        vecs.push_back('{4'b0000, 4'b0000, 2'd3, 1'b0});
        vecs.push_back('{4'b1001, 4'b0001, 2'd0, 1'b1});
        // Requester 1 arrives mid-grant and does not preempt; owner drops as limit expires.
        vecs.push_back('{4'b0011, 4'b0001, 2'd0, 1'b1});
        vecs.push_back('{4'b0011, 4'b0001, 2'd0, 1'b1});
        vecs.push_back('{4'b0011, 4'b0001, 2'd0, 1'b1});
        vecs.push_back('{4'b0010, 4'b0010, 2'd1, 1'b1});
        // Sole owner 1 saturates, then requester 0 appears and takes over at once.
        vecs.push_back('{4'b0010, 4'b0010, 2'd1, 1'b1});
        vecs.push_back('{4'b0010, 4'b0010, 2'd1, 1'b1});
        vecs.push_back('{4'b0010, 4'b0010, 2'd1, 1'b1});
        vecs.push_back('{4'b0010, 4'b0010, 2'd1, 1'b1});
        vecs.push_back('{4'b0011, 4'b0001, 2'd0, 1'b1});
        vecs.push_back('{4'b0000, 4'b0000, 2'd0, 1'b0});

        // Outputs are cleared by reset before any clock edge.
        #2;
        checkOutput("reset_async", 4'b0000, 2'd0, 1'b0);
        repeat (2) @(posedge clk_i);
        #1;
        checkOutput("reset_held", 4'b0000, 2'd0, 1'b0);
        @(negedge clk_i);
        rst_n_i = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].req);
            checkOutput($sformatf("vec%0d", i), vecs[i].grant, vecs[i].sel, vecs[i].busy);
        end

        // Sole requester held for 20 cycles keeps the grant throughout (pointer is 1).
        for (int i = 0; i < 20; i++) begin
            applyStimulus(4'b0010);
            checkOutput($sformatf("sole%0d", i), 4'b0010, 2'd1, 1'b1);
        end

        // Everyone requests: saturated owner 1 yields at once to requester 2.
        applyStimulus(4'b1111);
        checkOutput("expiry_after_sole", 4'b0100, 2'd2, 1'b1);

        // Asynchronous reset in the middle of a cycle while all request.
        @(negedge clk_i);
        #2;
        rst_n_i = 1'b0;
        #1;
        checkOutput("reset_midcycle", 4'b0000, 2'd0, 1'b0);
        @(posedge clk_i);
        #1;
        checkOutput("reset_mid_held", 4'b0000, 2'd0, 1'b0);
        @(negedge clk_i);
        rst_n_i = 1'b1;
        @(posedge clk_i);
        #1;
        checkOutput("after_reset_ptr0", 4'b0001, 2'd0, 1'b1);

        applyStimulus(4'b0000);
        checkOutput("final_idle", 4'b0000, 2'd0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
